// File: rtl/ppu_pkg.sv
// Shared types for the VRAM read-port arbiter: owner encoding and the read tag
// that travels alongside each BRAM access until its data returns.
package ppu_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BG   = 2'd1,
    SPR  = 2'd2,
    CPU  = 2'd3
  } vram_owner_t;

  typedef struct packed {
    logic        valid;
    vram_owner_t owner;
    logic        in_range;
  } read_tag_t;

  localparam logic [1:0]  PPU_MODE_DRAW = 2'd3;
  localparam logic [15:0] VRAM_SIZE     = 16'h2000;

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line of read tags matched to the BRAM read latency; the head stage lines
// up with the cycle the BRAM data is valid.
module read_tag_pipe
  import ppu_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  read_tag_t tag_in,
  output read_tag_t head_out,
  output logic      empty_out
);

  read_tag_t stage_q [STAGES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    empty_out = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (stage_q[i].valid) empty_out = 1'b0;
    end
  end

  assign head_out = stage_q[STAGES-1];

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Shares the single VRAM read port between BG fetcher, sprite fetcher and CPU,
// enforcing PPU-only access while drawing and CPU-only access otherwise.
//   state | meaning
//   NONE  | port idle, owner picked on next tclk
//   BG    | background fetcher owns the port for a tile fetch
//   SPR   | sprite fetcher owns the port
//   CPU   | CPU bus owns the port (outside Drawing)
module vram_fetch_arbiter
  import ppu_pkg::*;
#(
  parameter int          RD_LATENCY = 2,
  parameter logic [15:0] VRAM_BASE  = 16'h8000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  ppu_mode_in,
  input  logic        bg_hold_in,
  input  logic        bg_req_in,
  input  logic [15:0] bg_addr_in,
  input  logic        spr_hold_in,
  input  logic        spr_req_in,
  input  logic [15:0] spr_addr_in,
  input  logic        cpu_req_in,
  input  logic [15:0] cpu_addr_in,
  output logic        mem_free_out,
  output logic        bg_grant_out,
  output logic        spr_grant_out,
  output logic        cpu_grant_out,
  output logic [12:0] vram_addr_out,
  output logic        vram_rd_out,
  input  logic [7:0]  vram_data_in,
  output logic [7:0]  rd_data_out,
  output logic        bg_valid_out,
  output logic        spr_valid_out,
  output logic        cpu_valid_out
);

  vram_owner_t owner_q, owner_d, none_next;
  read_tag_t   issue_q, issue_tag, head;
  logic        vram_rd_q;
  logic [12:0] vram_addr_q;
  logic        pipe_empty, in_flight, mode_draw, can_leave;
  logic        issue_hit, issue_allowed, issue_in_range;
  vram_owner_t issue_owner;
  logic [15:0] issue_addr, issue_offset;

  assign mode_draw = (ppu_mode_in == PPU_MODE_DRAW);
  // issue_q is the tag of the read on the BRAM port right now; it counts as in flight
  assign in_flight = issue_q.valid || !pipe_empty;

  // Owner request first; otherwise a single blocked requester gets an 0xFF reply.
  always_comb begin
    issue_hit     = 1'b0;
    issue_owner   = NONE;
    issue_addr    = '0;
    issue_allowed = 1'b0;
    if (tclk_in) begin
      if (owner_q == BG && bg_req_in) begin
        issue_hit = 1'b1; issue_owner = BG; issue_addr = bg_addr_in; issue_allowed = mode_draw;
      end else if (owner_q == SPR && spr_req_in) begin
        issue_hit = 1'b1; issue_owner = SPR; issue_addr = spr_addr_in; issue_allowed = mode_draw;
      end else if (owner_q == CPU && cpu_req_in) begin
        issue_hit = 1'b1; issue_owner = CPU; issue_addr = cpu_addr_in; issue_allowed = !mode_draw;
      end else if (cpu_req_in && mode_draw) begin
        issue_hit = 1'b1; issue_owner = CPU; issue_addr = cpu_addr_in;
      end else if (spr_req_in && !mode_draw) begin
        issue_hit = 1'b1; issue_owner = SPR; issue_addr = spr_addr_in;
      end else if (bg_req_in && !mode_draw) begin
        issue_hit = 1'b1; issue_owner = BG; issue_addr = bg_addr_in;
      end
    end
  end

  assign issue_offset   = issue_addr - VRAM_BASE;
  assign issue_in_range = issue_allowed && (issue_offset < VRAM_SIZE);

  always_comb begin
    issue_tag          = '0;
    issue_tag.valid    = issue_hit;
    issue_tag.owner    = issue_owner;
    issue_tag.in_range = issue_in_range;
  end

  always_comb begin
    none_next = NONE;
    if (mode_draw) begin
      if (spr_hold_in)     none_next = SPR;
      else if (bg_hold_in) none_next = BG;
    end else if (cpu_req_in) begin
      none_next = CPU;
    end
  end

  // Hand-off only once every read of the current owner has returned.
  assign can_leave = !in_flight && !issue_hit;

  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      NONE: owner_d = none_next;
      BG:   if ((!bg_hold_in || !mode_draw) && can_leave) owner_d = none_next;
      SPR:  if ((!spr_hold_in || !mode_draw) && can_leave) owner_d = none_next;
      CPU:  if ((!cpu_req_in || mode_draw) && can_leave) owner_d = none_next;
      default: owner_d = NONE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner_q     <= NONE;
      issue_q     <= '0;
      vram_rd_q   <= 1'b0;
      vram_addr_q <= '0;
    end else begin
      issue_q   <= issue_tag;
      vram_rd_q <= issue_hit && issue_in_range;
      if (issue_hit && issue_in_range) vram_addr_q <= issue_offset[12:0];
      if (tclk_in) owner_q <= owner_d;
    end
  end

  read_tag_pipe #(.STAGES(RD_LATENCY)) u_tag_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .tag_in    (issue_q),
    .head_out  (head),
    .empty_out (pipe_empty)
  );

  assign vram_rd_out   = vram_rd_q;
  assign vram_addr_out = vram_addr_q;
  assign bg_grant_out  = (owner_q == BG);
  assign spr_grant_out = (owner_q == SPR);
  assign cpu_grant_out = (owner_q == CPU);
  assign mem_free_out  = !bg_hold_in && !in_flight;

  assign rd_data_out   = (head.valid && head.in_range) ? vram_data_in : 8'hFF;
  assign bg_valid_out  = head.valid && (head.owner == BG);
  assign spr_valid_out = head.valid && (head.owner == SPR);
  assign cpu_valid_out = head.valid && (head.owner == CPU);

endmodule
